// File: rtl/fifo_ext_pkg.sv
// Shared definitions for the fifo_ext buffer: depth helper, default levels and
// the legality check applied to the almost-full / almost-empty thresholds.
package fifo_ext_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_AE_LEVEL   = 2;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  // AF_LEVEL must lie in 1..DEPTH and AE_LEVEL in 0..DEPTH-1.
  function automatic bit levels_ok(input int addr_width, input int af_level,
                                   input int ae_level);
    int depth;
    depth = depth_of(addr_width);
    return (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ext_if.sv
// Request/status bundle of fifo_ext. The master drives requests; the slave
// (the FIFO) returns head data, occupancy and flags.
// Handshake: no valid/ready pair here -- enqueue/dequeue are requests sampled on
// every rising edge; an enqueue is accepted when not full or when paired with a
// dequeue, a dequeue is accepted when not empty; dropped requests raise the
// sticky overflow/underflow flags.
interface fifo_ext_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  enqueue;
  logic                  dequeue;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  flush;
  logic                  clear_err;
  logic [DATA_WIDTH-1:0] data_o;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;
  logic [ADDR_WIDTH:0]   high_water;

  modport master (
    output enqueue, dequeue, data_i, flush, clear_err,
    input  data_o, count, empty, full, almost_empty, almost_full,
           overflow, underflow, high_water
  );

  modport slave (
    input  enqueue, dequeue, data_i, flush, clear_err,
    output data_o, count, empty, full, almost_empty, almost_full,
           overflow, underflow, high_water
  );
endinterface

// File: rtl/fifo_ext_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read. Contents are
// never reset; the FIFO's pointers decide which words are meaningful.
module fifo_ext_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_ext.sv
// First-word-fall-through FIFO with almost flags, flush, sticky error flags and
// a high-water-mark counter. Pointer, count and flag logic live here.
module fifo_ext
  import fifo_ext_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = depth_of(ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
  input logic       clk,
  input logic       rst,
  fifo_ext_if.slave bus
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (!levels_ok(ADDR_WIDTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $error("fifo_ext: AF_LEVEL or AE_LEVEL out of range");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         high_water_q, high_water_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  empty_w, full_w;
  logic                  bypass, we, re;
  logic [DATA_WIDTH-1:0] rd_data;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  // Empty with both requests: the word passes straight through, state untouched.
  assign bypass = empty_w & bus.enqueue & bus.dequeue & ~bus.flush;
  assign we     = bus.enqueue & (~full_w | bus.dequeue) & ~bypass & ~bus.flush;
  assign re     = bus.dequeue & ~empty_w & ~bus.flush;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    high_water_d = high_water_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (we) wr_ptr_d = wr_ptr_q + 1'b1;
      if (re) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(we) - CW'(re);
    end

    if (bus.clear_err) begin
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
      high_water_d = count_d;
    end else if (count_d > high_water_q) begin
      high_water_d = count_d;
    end

    // New errors are applied after the clear so that set wins.
    if (!bus.flush && bus.enqueue && full_w && !bus.dequeue) overflow_d  = 1'b1;
    if (!bus.flush && bus.dequeue && empty_w && !bus.enqueue) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      high_water_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      high_water_q <= high_water_d;
    end
  end

  fifo_ext_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.data_i),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    bus.data_o = '0;
    if (!empty_w)    bus.data_o = rd_data;
    else if (bypass) bus.data_o = bus.data_i;
  end

  assign bus.count        = count_q;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.high_water   = high_water_q;

endmodule

// File: tb/tb_fifo_ext.sv
// Bench for fifo_ext (DEPTH=4, AF=3, AE=1): directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a queue model.
module tb_fifo_ext;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_ext_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_ext #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic e, input logic d, input logic [DW-1:0] din,
                       input logic f, input logic c, input logic r);
    @(posedge clk);
    #1;
    bus.enqueue   = e;
    bus.dequeue   = d;
    bus.data_i    = din;
    bus.flush     = f;
    bus.clear_err = c;
    rst           = r;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enq(input logic [DW-1:0] v);
    drive(1'b1, 1'b0, v, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic deq();
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- behavioural model + compare ----------------
  logic [DW-1:0] exp_q[$];
  bit model_on = 1'b0;
  int m_ovf = 0, m_unf = 0, m_hw = 0;

  always @(negedge clk) begin
    int n, exp_do, new_n;
    bit pass, do_re, do_we;
    n = exp_q.size();
    pass = (n == 0) && bus.enqueue && bus.dequeue && !bus.flush;
    if (model_on) begin
      exp_do = (n != 0) ? int'(exp_q[0]) : (pass ? int'(bus.data_i) : 0);
      check("m_data_o",       int'(bus.data_o), exp_do);
      check("m_count",        int'(bus.count), n);
      check("m_empty",        int'(bus.empty), int'(n == 0));
      check("m_full",         int'(bus.full), int'(n == DEPTH));
      check("m_almost_empty", int'(bus.almost_empty), int'(n <= AE));
      check("m_almost_full",  int'(bus.almost_full), int'(n >= AF));
      check("m_overflow",     int'(bus.overflow), m_ovf);
      check("m_underflow",    int'(bus.underflow), m_unf);
      check("m_high_water",   int'(bus.high_water), m_hw);
    end
    if (rst) begin
      exp_q.delete();
      m_ovf = 0; m_unf = 0; m_hw = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (bus.flush) begin
        exp_q.delete();
      end else if (!pass) begin
        do_re = bus.dequeue && (n > 0);
        do_we = bus.enqueue && ((n < DEPTH) || bus.dequeue);
        if (do_re) void'(exp_q.pop_front());
        if (do_we) exp_q.push_back(bus.data_i);
      end
      new_n = exp_q.size();
      if (bus.clear_err) begin
        m_ovf = 0; m_unf = 0; m_hw = new_n;
      end else if (new_n > m_hw) begin
        m_hw = new_n;
      end
      if (!bus.flush && bus.enqueue && (n == DEPTH) && !bus.dequeue) m_ovf = 1;
      if (!bus.flush && bus.dequeue && (n == 0) && !bus.enqueue) m_unf = 1;
    end
  end

  // ---------------- directed scenarios with literal expectations ----------------
  initial begin
    bus.enqueue = 1'b0; bus.dequeue = 1'b0; bus.data_i = '0;
    bus.flush = 1'b0; bus.clear_err = 1'b0;

    // 1. Reset, fill and drain
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    enq(8'h11); @(negedge clk);
    check("rst_count", int'(bus.count), 0);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_ae", int'(bus.almost_empty), 1);
    check("rst_full", int'(bus.full), 0);
    check("rst_af", int'(bus.almost_full), 0);
    check("rst_data_o", int'(bus.data_o), 0);
    enq(8'h22); @(negedge clk);
    check("fill_count1", int'(bus.count), 1);
    check("fill_head", int'(bus.data_o), 'h11);
    enq(8'h33); @(negedge clk);
    check("fill_count2", int'(bus.count), 2);
    enq(8'h44); @(negedge clk);
    check("fill_count3", int'(bus.count), 3);
    check("fill_af3", int'(bus.almost_full), 1);
    check("fill_full3", int'(bus.full), 0);
    enq(8'h55); @(negedge clk);
    check("fill_count4", int'(bus.count), 4);
    check("fill_full4", int'(bus.full), 1);
    deq(); @(negedge clk);
    check("ovf_count", int'(bus.count), 4);
    check("ovf_flag", int'(bus.overflow), 1);
    check("drain_d0", int'(bus.data_o), 'h11);
    deq(); @(negedge clk); check("drain_d1", int'(bus.data_o), 'h22);
    deq(); @(negedge clk); check("drain_d2", int'(bus.data_o), 'h33);
    deq(); @(negedge clk); check("drain_d3", int'(bus.data_o), 'h44);
    idle(); @(negedge clk);
    check("drain_empty", int'(bus.empty), 1);

    // 2. Wrap-around
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    enq(8'h01); enq(8'h02); enq(8'h03);
    deq(); deq(); deq();
    enq(8'hA0); enq(8'hA1); enq(8'hA2); enq(8'hA3);
    deq(); @(negedge clk);
    check("wrap_hw", int'(bus.high_water), 4);
    check("wrap_d0", int'(bus.data_o), 'hA0);
    deq(); @(negedge clk); check("wrap_d1", int'(bus.data_o), 'hA1);
    deq(); @(negedge clk); check("wrap_d2", int'(bus.data_o), 'hA2);
    deq(); @(negedge clk); check("wrap_d3", int'(bus.data_o), 'hA3);

    // 3. Full with simultaneous enqueue+dequeue
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    enq(8'h11); enq(8'h22); enq(8'h33); enq(8'h44);
    drive(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0); @(negedge clk);
    check("fulleq_head0", int'(bus.data_o), 'h11);
    deq(); @(negedge clk);
    check("fulleq_count", int'(bus.count), 4);
    check("fulleq_ovf", int'(bus.overflow), 0);
    check("fulleq_d0", int'(bus.data_o), 'h22);
    deq(); @(negedge clk); check("fulleq_d1", int'(bus.data_o), 'h33);
    deq(); @(negedge clk); check("fulleq_d2", int'(bus.data_o), 'h44);
    deq(); @(negedge clk); check("fulleq_d3", int'(bus.data_o), 'h99);

    // 4. Empty bypass and underflow
    drive(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0); @(negedge clk);
    check("byp_data", int'(bus.data_o), 'h5A);
    check("byp_count", int'(bus.count), 0);
    deq(); @(negedge clk);
    check("byp_count_after", int'(bus.count), 0);
    check("byp_no_unf", int'(bus.underflow), 0);
    check("byp_no_ovf", int'(bus.overflow), 0);
    idle(); @(negedge clk);
    check("unf_flag", int'(bus.underflow), 1);
    check("unf_data", int'(bus.data_o), 0);

    // 5. Flush and clear_err
    enq(8'h01); enq(8'h02); enq(8'h03); enq(8'h04); enq(8'h05);
    deq();
    drive(1'b1, 1'b0, 8'h06, 1'b1, 1'b0, 1'b0); @(negedge clk);
    check("fl_pre_count", int'(bus.count), 3);
    check("fl_pre_ovf", int'(bus.overflow), 1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0); @(negedge clk);
    check("fl_count", int'(bus.count), 0);
    check("fl_empty", int'(bus.empty), 1);
    check("fl_ovf", int'(bus.overflow), 1);
    check("fl_hw", int'(bus.high_water), 4);
    idle(); @(negedge clk);
    check("ce_ovf", int'(bus.overflow), 0);
    check("ce_unf", int'(bus.underflow), 0);
    check("ce_hw", int'(bus.high_water), 0);

    // 6. Reset mid-operation
    enq(8'h31); enq(8'h32);
    drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1); @(negedge clk);
    check("rm_pre_count", int'(bus.count), 2);
    enq(8'h7E); @(negedge clk);
    check("rm_count", int'(bus.count), 0);
    check("rm_empty", int'(bus.empty), 1);
    check("rm_af", int'(bus.almost_full), 0);
    check("rm_hw", int'(bus.high_water), 0);
    check("rm_data", int'(bus.data_o), 0);
    idle(); @(negedge clk);
    check("rm_new_head", int'(bus.data_o), 'h7E);
    check("rm_new_count", int'(bus.count), 1);

    // Randomized traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 3000; i++) begin
      int pe, pd;
      pe = ((i / 150) % 2 == 0) ? 75 : 30;
      pd = ((i / 150) % 2 == 0) ? 30 : 75;
      drive(logic'($urandom_range(99) < pe), logic'($urandom_range(99) < pd),
            DW'($urandom_range(255)), logic'($urandom_range(59) == 0),
            logic'($urandom_range(39) == 0), logic'($urandom_range(299) == 0));
    end
    idle(); idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
